// File: rtl/cpu_pkg.sv
// Shared CPU constants and encodings for the ID/EX operand stage.
// alu_ctrl_e values are the ALU opcodes that travel down the pipeline.
package cpu_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;
    localparam int CTRL_W  = 5;

    typedef enum logic [CTRL_W-1:0] {
        ALU_NOP  = 5'd0,
        ALU_ADD  = 5'd1,
        ALU_SUB  = 5'd2,
        ALU_SLL  = 5'd3,
        ALU_SLT  = 5'd4,
        ALU_SLTU = 5'd5,
        ALU_XOR  = 5'd6,
        ALU_SRL  = 5'd7,
        ALU_SRA  = 5'd8,
        ALU_OR   = 5'd9,
        ALU_AND  = 5'd10,
        ALU_LUI  = 5'd11,
        ALU_BEQ  = 5'd12,
        ALU_BNE  = 5'd13,
        ALU_BLTS = 5'd14,
        ALU_BGES = 5'd15,
        ALU_BGEU = 5'd16
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Decode-slot bundle between the ID stage (master) and the ID/EX register (slave).
// Handshake: id_valid offers an instruction and load_use_stall is the not-ready reply;
// the slot is consumed on an edge with id_valid=1, load_use_stall=0, mem_stall=0, flush=0.
interface id_ex_operand_stage_if
    import cpu_pkg::*;
#(
    parameter int XLEN    = cpu_pkg::XLEN,
    parameter int RADDR_W = cpu_pkg::RADDR_W,
    parameter int CTRL_W  = cpu_pkg::CTRL_W
);
    logic               id_valid;
    logic [CTRL_W-1:0]  id_alu_ctrl;
    logic [XLEN-1:0]    id_pc;
    logic [XLEN-1:0]    id_rs1_data;
    logic [XLEN-1:0]    id_rs2_data;
    logic [XLEN-1:0]    id_imm;
    logic [RADDR_W-1:0] id_rs1_addr;
    logic [RADDR_W-1:0] id_rs2_addr;
    logic [RADDR_W-1:0] id_rd_addr;
    logic               id_use_rs1;
    logic               id_use_rs2;
    logic               id_sel_pc;
    logic               id_sel_imm;
    logic               id_reg_write;
    logic               id_mem_read;
    logic               id_mem_write;
    logic               load_use_stall;

    modport master (
        output id_valid, id_alu_ctrl, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1_addr, id_rs2_addr, id_rd_addr, id_use_rs1, id_use_rs2,
               id_sel_pc, id_sel_imm, id_reg_write, id_mem_read, id_mem_write,
        input  load_use_stall
    );

    modport slave (
        input  id_valid, id_alu_ctrl, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1_addr, id_rs2_addr, id_rd_addr, id_use_rs1, id_use_rs2,
               id_sel_pc, id_sel_imm, id_reg_write, id_mem_read, id_mem_write,
        output load_use_stall
    );
endinterface

// File: rtl/id_ex_operand_stage_fwd.sv
// Forward-source select and data mux for one ALU operand.
// EX/MEM has priority over MEM/WB; x0 is never forwarded and always reads 0.
module operand_fwd_mux
    import cpu_pkg::*;
#(
    parameter int XLEN    = cpu_pkg::XLEN,
    parameter int RADDR_W = cpu_pkg::RADDR_W
) (
    input  logic [RADDR_W-1:0] rs_addr,
    input  logic [XLEN-1:0]    rf_data,
    input  logic [RADDR_W-1:0] exmem_rd,
    input  logic               exmem_reg_write,
    input  logic [XLEN-1:0]    exmem_result,
    input  logic [RADDR_W-1:0] memwb_rd,
    input  logic               memwb_reg_write,
    input  logic [XLEN-1:0]    memwb_result,
    output logic [XLEN-1:0]    operand
);
    fwd_sel_e sel;

    always_comb begin
        sel = FWD_RF;
        if (rs_addr != '0) begin
            if (exmem_reg_write && (exmem_rd == rs_addr)) begin
                sel = FWD_EXMEM;
            end else if (memwb_reg_write && (memwb_rd == rs_addr)) begin
                sel = FWD_MEMWB;
            end
        end
    end

    always_comb begin
        case (sel)
            FWD_EXMEM: operand = exmem_result;
            FWD_MEMWB: operand = memwb_result;
            default:   operand = (rs_addr == '0) ? '0 : rf_data;
        endcase
    end
endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register plus operand selection feeding the ALU.
// Handles EX/MEM and MEM/WB forwarding, load-use bubbles, flush and downstream hold.
module id_ex_operand_stage
    import cpu_pkg::*;
#(
    parameter int XLEN    = cpu_pkg::XLEN,
    parameter int RADDR_W = cpu_pkg::RADDR_W,
    parameter int CTRL_W  = cpu_pkg::CTRL_W
) (
    input  logic                  clk,
    input  logic                  rst,
    id_ex_operand_stage_if.slave  id,
    input  logic                  mem_stall,
    input  logic                  flush,
    input  logic [RADDR_W-1:0]    exmem_rd,
    input  logic                  exmem_reg_write,
    input  logic [XLEN-1:0]       exmem_result,
    input  logic [RADDR_W-1:0]    memwb_rd,
    input  logic                  memwb_reg_write,
    input  logic [XLEN-1:0]       memwb_result,
    output logic [CTRL_W-1:0]     alu_ctrl,
    output logic [XLEN-1:0]       alu_in1,
    output logic [XLEN-1:0]       alu_in2,
    output logic [XLEN-1:0]       ex_store_data,
    output logic [XLEN-1:0]       ex_pc,
    output logic [XLEN-1:0]       ex_imm,
    output logic [RADDR_W-1:0]    ex_rd,
    output logic                  ex_valid,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write
);
    logic [RADDR_W-1:0] rs1_addr_q, rs2_addr_q;
    logic [XLEN-1:0]    rs1_data_q, rs2_data_q;
    logic               sel_pc_q, sel_imm_q;
    logic [XLEN-1:0]    fwd_rs1, fwd_rs2;
    logic               rs1_hit, rs2_hit, load_use;

    // A load in EX cannot forward its data yet, so a dependent ID instruction waits one cycle.
    assign rs1_hit  = id.id_use_rs1 && (id.id_rs1_addr == ex_rd);
    assign rs2_hit  = id.id_use_rs2 && (id.id_rs2_addr == ex_rd);
    assign load_use = !flush && ex_valid && ex_mem_read && (ex_rd != '0) &&
                      id.id_valid && (rs1_hit || rs2_hit);
    assign id.load_use_stall = load_use;

    always_ff @(posedge clk) begin
        if (!rst || (!mem_stall && (flush || load_use))) begin
            ex_valid     <= 1'b0;
            alu_ctrl     <= CTRL_W'(ALU_NOP);
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_pc        <= '0;
            ex_imm       <= '0;
            ex_rd        <= '0;
            rs1_addr_q   <= '0;
            rs2_addr_q   <= '0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            sel_pc_q     <= 1'b0;
            sel_imm_q    <= 1'b0;
        end else if (!mem_stall) begin
            ex_valid     <= id.id_valid;
            alu_ctrl     <= id.id_alu_ctrl;
            ex_reg_write <= id.id_reg_write;
            ex_mem_read  <= id.id_mem_read;
            ex_mem_write <= id.id_mem_write;
            ex_pc        <= id.id_pc;
            ex_imm       <= id.id_imm;
            ex_rd        <= id.id_rd_addr;
            rs1_addr_q   <= id.id_rs1_addr;
            rs2_addr_q   <= id.id_rs2_addr;
            rs1_data_q   <= id.id_rs1_data;
            rs2_data_q   <= id.id_rs2_data;
            sel_pc_q     <= id.id_sel_pc;
            sel_imm_q    <= id.id_sel_imm;
        end
    end

    operand_fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs1 (
        .rs_addr         (rs1_addr_q),
        .rf_data         (rs1_data_q),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .operand         (fwd_rs1)
    );

    operand_fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs2 (
        .rs_addr         (rs2_addr_q),
        .rf_data         (rs2_data_q),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .operand         (fwd_rs2)
    );

    assign alu_in1       = sel_pc_q  ? ex_pc  : fwd_rs1;
    assign alu_in2       = sel_imm_q ? ex_imm : fwd_rs2;
    assign ex_store_data = fwd_rs2;
endmodule
